// File: rtl/avalon_mem_arbiter.sv
// Two-master Avalon-MM arbiter in front of a single RAM slave.
// m0 is the CPU, m1 is the loader/test master. A one-cycle arbitration state
// (IDLE) sits between every pair of transfers, so the bus is handed over on
// a clean boundary. Ties are broken round-robin against the last master served.
// An owner holds the bus until its transfer completes or it drops its request.
module avalon_mem_arbiter (
  input  logic        clk,
  input  logic        reset,

  // CPU master
  input  logic [31:0] m0_address,
  input  logic [31:0] m0_writedata,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [3:0]  m0_byteenable,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,

  // Loader / test master
  input  logic [31:0] m1_address,
  input  logic [31:0] m1_writedata,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [3:0]  m1_byteenable,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,

  // RAM slave
  output logic [31:0] s_address,
  output logic [31:0] s_writedata,
  output logic        s_read,
  output logic        s_write,
  output logic [3:0]  s_byteenable,
  input  logic        s_waitrequest,
  input  logic [31:0] s_readdata,

  // Status
  output logic [1:0]  grant,
  output logic        proto_err
);

  // One-hot owner encoding doubles as the grant vector.
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] OWN0 = 2'b01;
  localparam logic [1:0] OWN1 = 2'b10;

  logic [1:0] state_q, state_d;
  // 1 = m1 was served last, so m0 wins the next tie.
  logic       last_m1_q, last_m1_d;
  logic       err_q, err_d;

  logic       m0_req, m1_req;
  logic       own0, own1;

  assign m0_req = m0_read | m0_write;
  assign m1_req = m1_read | m1_write;

  assign own0 = (state_q == OWN0);
  assign own1 = (state_q == OWN1);

  // Next-state: arbitrate in IDLE, track completion or abandonment when owned.
  always_comb begin
    state_d   = state_q;
    last_m1_d = last_m1_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (m0_req && m1_req) begin
          state_d = last_m1_q ? OWN0 : OWN1;
        end else if (m0_req) begin
          state_d = OWN0;
        end else if (m1_req) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        // Simultaneous read and write is illegal; it is forwarded as a write.
        if (m0_read && m0_write) begin
          err_d = 1'b1;
        end
        if (!m0_req) begin
          // Request withdrawn before the slave accepted it.
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (!s_waitrequest) begin
          state_d   = IDLE;
          last_m1_d = 1'b0;
        end
      end
      OWN1: begin
        if (m1_read && m1_write) begin
          err_d = 1'b1;
        end
        if (!m1_req) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (!s_waitrequest) begin
          state_d   = IDLE;
          last_m1_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; reset abandons any open transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      last_m1_q <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_m1_q <= last_m1_d;
      err_q     <= err_d;
    end
  end

  // Bus mux: route the owner straight through, park everything else at zero.
  always_comb begin
    s_address      = 32'h0;
    s_writedata    = 32'h0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_byteenable   = 4'h0;
    m0_waitrequest = 1'b1;
    m0_readdata    = 32'h0;
    m1_waitrequest = 1'b1;
    m1_readdata    = 32'h0;
    if (own0) begin
      s_address      = m0_address;
      s_writedata    = m0_writedata;
      s_read         = m0_read & ~m0_write;
      s_write        = m0_write;
      s_byteenable   = m0_byteenable;
      m0_waitrequest = s_waitrequest;
      m0_readdata    = s_readdata;
    end else if (own1) begin
      s_address      = m1_address;
      s_writedata    = m1_writedata;
      s_read         = m1_read & ~m1_write;
      s_write        = m1_write;
      s_byteenable   = m1_byteenable;
      m1_waitrequest = s_waitrequest;
      m1_readdata    = s_readdata;
    end
  end

  assign grant     = {own1, own0};
  assign proto_err = err_q;

endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// Directed bench for avalon_mem_arbiter: a per-cycle reference model of bus
// ownership plus hand-computed literal checks for each scenario.
module tb_avalon_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m0_address, m0_writedata, m0_readdata;
  logic        m0_read, m0_write, m0_waitrequest;
  logic [3:0]  m0_byteenable;
  logic [31:0] m1_address, m1_writedata, m1_readdata;
  logic        m1_read, m1_write, m1_waitrequest;
  logic [3:0]  m1_byteenable;
  logic [31:0] s_address, s_writedata, s_readdata;
  logic        s_read, s_write, s_waitrequest;
  logic [3:0]  s_byteenable;
  logic [1:0]  grant;
  logic        proto_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  avalon_mem_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .m0_address     (m0_address),
    .m0_writedata   (m0_writedata),
    .m0_read        (m0_read),
    .m0_write       (m0_write),
    .m0_byteenable  (m0_byteenable),
    .m0_waitrequest (m0_waitrequest),
    .m0_readdata    (m0_readdata),
    .m1_address     (m1_address),
    .m1_writedata   (m1_writedata),
    .m1_read        (m1_read),
    .m1_write       (m1_write),
    .m1_byteenable  (m1_byteenable),
    .m1_waitrequest (m1_waitrequest),
    .m1_readdata    (m1_readdata),
    .s_address      (s_address),
    .s_writedata    (s_writedata),
    .s_read         (s_read),
    .s_write        (s_write),
    .s_byteenable   (s_byteenable),
    .s_waitrequest  (s_waitrequest),
    .s_readdata     (s_readdata),
    .grant          (grant),
    .proto_err      (proto_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // own: 0 = nobody, 1 = m0, 2 = m1. last: index of master served last.
  int  m_own  = 0;
  int  m_last = 1;
  bit  m_err  = 1'b0;
  bit  model_ok = 1'b0;

  logic [1:0]  rd, wr, req;
  logic [31:0] ma [2];
  logic [31:0] md [2];
  logic [3:0]  mb [2];
  assign rd  = {m1_read, m0_read};
  assign wr  = {m1_write, m0_write};
  assign req = rd | wr;
  assign ma[0] = m0_address;
  assign ma[1] = m1_address;
  assign md[0] = m0_writedata;
  assign md[1] = m1_writedata;
  assign mb[0] = m0_byteenable;
  assign mb[1] = m1_byteenable;

  always @(posedge clk) begin
    if (reset) begin
      m_own    <= 0;
      m_last   <= 1;
      m_err    <= 1'b0;
      model_ok <= 1'b1;
    end else if (model_ok) begin
      if (m_own == 0) begin
        if (req[0] && req[1]) m_own <= 2 - m_last;
        else if (req[0])      m_own <= 1;
        else if (req[1])      m_own <= 2;
      end else begin
        if (rd[m_own-1] && wr[m_own-1]) m_err <= 1'b1;
        if (!req[m_own-1]) begin
          m_err <= 1'b1;
          m_own <= 0;
        end else if (!s_waitrequest) begin
          m_last <= m_own - 1;
          m_own  <= 0;
        end
      end
    end
  end

  // Compare every cycle once the model has seen a reset edge.
  always @(negedge clk) begin
    if (model_ok) begin
      automatic logic [1:0]  e_grant = 2'b00;
      automatic logic [31:0] e_addr = 0, e_data = 0;
      automatic logic [3:0]  e_be = 0;
      automatic logic        e_rd = 0, e_wr = 0;
      automatic logic [1:0]  e_wait = 2'b11;
      automatic logic [31:0] e_rdata [2];
      e_rdata[0] = 0;
      e_rdata[1] = 0;
      if (m_own != 0) begin
        e_grant[m_own-1] = 1'b1;
        e_addr = ma[m_own-1];
        e_data = md[m_own-1];
        e_be   = mb[m_own-1];
        e_wr   = wr[m_own-1];
        e_rd   = rd[m_own-1] && !wr[m_own-1];
        e_wait[m_own-1]  = s_waitrequest;
        e_rdata[m_own-1] = s_readdata;
      end
      chk("cmp_grant", {30'b0, grant}, {30'b0, e_grant});
      chk("cmp_s_address", s_address, e_addr);
      chk("cmp_s_writedata", s_writedata, e_data);
      chk("cmp_s_byteenable", {28'b0, s_byteenable}, {28'b0, e_be});
      chk("cmp_s_read", {31'b0, s_read}, {31'b0, e_rd});
      chk("cmp_s_write", {31'b0, s_write}, {31'b0, e_wr});
      chk("cmp_m0_waitrequest", {31'b0, m0_waitrequest}, {31'b0, e_wait[0]});
      chk("cmp_m1_waitrequest", {31'b0, m1_waitrequest}, {31'b0, e_wait[1]});
      chk("cmp_m0_readdata", m0_readdata, e_rdata[0]);
      chk("cmp_m1_readdata", m1_readdata, e_rdata[1]);
      chk("cmp_proto_err", {31'b0, proto_err}, {31'b0, m_err});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic to_neg;
    @(negedge clk);
  endtask

  task automatic to_next;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_masters;
    m0_address = 0; m0_writedata = 0; m0_read = 0; m0_write = 0; m0_byteenable = 0;
    m1_address = 0; m1_writedata = 0; m1_read = 0; m1_write = 0; m1_byteenable = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_rr [8];
    exp_rr[0] = 2'b00; exp_rr[1] = 2'b01; exp_rr[2] = 2'b00; exp_rr[3] = 2'b10;
    exp_rr[4] = 2'b00; exp_rr[5] = 2'b01; exp_rr[6] = 2'b00; exp_rr[7] = 2'b10;

    reset = 1'b1;
    clear_masters();
    s_waitrequest = 1'b0;
    s_readdata    = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    to_neg();
    chk("rst_grant", {30'b0, grant}, 32'h0);
    chk("rst_m0_wait", {31'b0, m0_waitrequest}, 32'h1);
    chk("rst_m1_wait", {31'b0, m1_waitrequest}, 32'h1);
    chk("rst_m0_rdata", m0_readdata, 32'h0);
    chk("rst_m1_rdata", m1_readdata, 32'h0);
    chk("rst_s_rw", {30'b0, s_read, s_write}, 32'h0);
    chk("rst_s_addr", s_address, 32'h0);
    chk("rst_s_wdata", s_writedata, 32'h0);
    chk("rst_s_be", {28'b0, s_byteenable}, 32'h0);
    chk("rst_proto_err", {31'b0, proto_err}, 32'h0);
    to_next();

    // Single read by m0
    m0_read = 1'b1; m0_address = 32'h4; m0_byteenable = 4'hf;
    s_readdata = 32'h24030010;
    to_neg();
    chk("rd_c1_grant", {30'b0, grant}, 32'h0);
    chk("rd_c1_m0_wait", {31'b0, m0_waitrequest}, 32'h1);
    to_next();
    to_neg();
    chk("rd_c2_grant", {30'b0, grant}, 32'h1);
    chk("rd_c2_m0_wait", {31'b0, m0_waitrequest}, 32'h0);
    chk("rd_c2_m0_rdata", m0_readdata, 32'h24030010);
    chk("rd_c2_s_read", {31'b0, s_read}, 32'h1);
    chk("rd_c2_s_addr", s_address, 32'h4);
    to_next();
    clear_masters();
    to_neg();
    chk("rd_c3_grant", {30'b0, grant}, 32'h0);
    to_next();

    // Tie from reset: m0 first, then m1
    reset = 1'b1;
    to_next();
    reset = 1'b0;
    m0_write = 1'b1; m0_address = 32'h20; m0_writedata = 32'haaaa5555; m0_byteenable = 4'hf;
    m1_write = 1'b1; m1_address = 32'h30; m1_writedata = 32'h12345678; m1_byteenable = 4'h3;
    to_neg();
    chk("tie_c1_grant", {30'b0, grant}, 32'h0);
    to_next();
    to_neg();
    chk("tie_c2_grant", {30'b0, grant}, 32'h1);
    chk("tie_c2_m1_wait", {31'b0, m1_waitrequest}, 32'h1);
    chk("tie_c2_s_wdata", s_writedata, 32'haaaa5555);
    to_next();
    m0_write = 1'b0;
    to_neg();
    chk("tie_c3_grant", {30'b0, grant}, 32'h0);
    to_next();
    to_neg();
    chk("tie_c4_grant", {30'b0, grant}, 32'h2);
    chk("tie_c4_s_addr", s_address, 32'h30);
    chk("tie_c4_s_be", {28'b0, s_byteenable}, 32'h3);
    to_next();
    clear_masters();
    to_neg();
    chk("tie_c5_grant", {30'b0, grant}, 32'h0);
    to_next();

    // Slave stall: three wait cycles then completion
    m1_write = 1'b1; m1_address = 32'h10; m1_writedata = 32'h8; m1_byteenable = 4'hf;
    s_waitrequest = 1'b1;
    to_neg();
    chk("stall_idle_grant", {30'b0, grant}, 32'h0);
    to_next();
    for (int i = 0; i < 3; i++) begin
      to_neg();
      chk("stall_grant", {30'b0, grant}, 32'h2);
      chk("stall_s_write", {31'b0, s_write}, 32'h1);
      chk("stall_s_addr", s_address, 32'h10);
      chk("stall_m1_wait", {31'b0, m1_waitrequest}, 32'h1);
      to_next();
    end
    s_waitrequest = 1'b0;
    to_neg();
    chk("stall_done_grant", {30'b0, grant}, 32'h2);
    chk("stall_done_m1_wait", {31'b0, m1_waitrequest}, 32'h0);
    to_next();
    clear_masters();
    to_neg();
    chk("stall_after_grant", {30'b0, grant}, 32'h0);
    to_next();

    // Round-robin with both continuously requesting (m1 served last)
    m0_read = 1'b1; m0_address = 32'h100;
    m1_read = 1'b1; m1_address = 32'h200;
    s_readdata = 32'hcafef00d;
    for (int i = 0; i < 8; i++) begin
      to_neg();
      chk("rr_grant", {30'b0, grant}, {30'b0, exp_rr[i]});
      to_next();
    end
    clear_masters();
    to_next();

    // Protocol errors: read+write together, then request withdrawn mid-stall
    m0_read = 1'b1; m0_write = 1'b1; m0_address = 32'h44; m0_writedata = 32'h5a5a;
    s_waitrequest = 1'b1;
    to_neg();
    chk("perr_idle_grant", {30'b0, grant}, 32'h0);
    to_next();
    to_neg();
    chk("perr_rw_grant", {30'b0, grant}, 32'h1);
    chk("perr_rw_s_read", {31'b0, s_read}, 32'h0);
    chk("perr_rw_s_write", {31'b0, s_write}, 32'h1);
    to_next();
    to_neg();
    chk("perr_rw_flag", {31'b0, proto_err}, 32'h1);
    to_next();
    m0_read = 1'b0; m0_write = 1'b0;
    to_neg();
    chk("perr_drop_grant", {30'b0, grant}, 32'h1);
    to_next();
    to_neg();
    chk("perr_drop_idle", {30'b0, grant}, 32'h0);
    chk("perr_drop_flag", {31'b0, proto_err}, 32'h1);
    to_next();
    repeat (3) begin
      to_neg();
      chk("perr_sticky", {31'b0, proto_err}, 32'h1);
      to_next();
    end

    // Reset while m1 owns a stalled write
    m1_write = 1'b1; m1_address = 32'h40; m1_writedata = 32'h77;
    to_neg();
    chk("rmid_idle_grant", {30'b0, grant}, 32'h0);
    to_next();
    to_neg();
    chk("rmid_own_grant", {30'b0, grant}, 32'h2);
    to_next();
    reset = 1'b1;
    to_neg();
    chk("rmid_pre_grant", {30'b0, grant}, 32'h2);
    to_next();
    to_neg();
    chk("rmid_grant", {30'b0, grant}, 32'h0);
    chk("rmid_s_write", {31'b0, s_write}, 32'h0);
    chk("rmid_proto_err", {31'b0, proto_err}, 32'h0);
    chk("rmid_m1_wait", {31'b0, m1_waitrequest}, 32'h1);
    to_next();
    reset = 1'b0;
    clear_masters();
    s_waitrequest = 1'b0;
    repeat (3) to_next();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/avalon_mem_arbiter.md
AVALON_MEM_ARBITER -- requirements
Module: avalon_mem_arbiter

Interface
REQ-001 The block SHALL have exactly one clock and use synchronous, active-high reset; only `clk` and `reset` SHALL be used for these.
REQ-002 `clk`  input  1  system clock; all state updates on rising edge.
REQ-003 `reset`  input  1  synchronous active-high reset.
REQ-004 `m0_address`/`m0_writedata`  input  32 each  CPU master address and write data.
REQ-005 `m0_read`/`m0_write`  input  1 each  CPU master read and write strobes.
REQ-006 `m0_byteenable`  input  4  CPU master byte lanes.
REQ-007 `m0_waitrequest`  output  1  stall to CPU master.
REQ-008 `m0_readdata`  output  32  read data to CPU master.
REQ-009 `m1_*`  same set, widths and directions as m0_*  loader/test master (instruction preload).
REQ-010 `s_address`, `s_writedata`, `s_read`, `s_write`, `s_byteenable`  outputs  32/32/1/1/4  to the RAM slave.
REQ-011 `s_waitrequest`  input  1, `s_readdata`  input  32  from the RAM slave.
REQ-012 `grant`  output  2  one-hot current owner (bit0 = m0, bit1 = m1); 00 when idle.
REQ-013 `proto_err`  output  1  sticky protocol-error flag.

Function
REQ-014 A master "requests" when its read or write is high.
REQ-015 The FSM SHALL have the states IDLE, OWN0 and OWN1; `grant` SHALL be 01 in OWN0, 10 in OWN1 and 00 in IDLE.
REQ-016 IDLE with only mN requesting SHALL move to OWNn on the next edge.
REQ-017 IDLE with both requesting SHALL grant the master not served last (round-robin); after reset the last-served pointer SHALL be m1, so m0 wins the first tie.
REQ-018 Arbitration SHALL cost exactly one cycle: in IDLE, all s_read/s_write SHALL be 0 and both m_waitrequest SHALL be 1.
REQ-019 In OWNn, s_address/s_writedata/s_byteenable/s_read/s_write SHALL combinationally equal mN's signals.
REQ-020 In OWNn, mN_waitrequest SHALL equal s_waitrequest and mN_readdata SHALL equal s_readdata.
REQ-021 A transfer completes in a cycle in OWNn where mN requests and s_waitrequest = 0.
REQ-022 On completion the FSM SHALL return to IDLE and set last-served to n; the next access by any master costs one more arbitration cycle.
REQ-023 The non-owner's waitrequest SHALL be 1 at all times and its readdata SHALL be 0.
REQ-024 Slave outputs SHALL be 0 whenever not in OWNn; readdata to a non-owner SHALL be 0.
REQ-025 If mN deasserts read and write while in OWNn before completion, the FSM SHALL return to IDLE next edge without a completion, and `proto_err` SHALL set.
REQ-026 If mN asserts read and write together in OWNn, the cycle SHALL be forwarded as a write only (s_read = 0) and `proto_err` SHALL set.
REQ-027 A request arriving while the other master owns the bus SHALL be held (waitrequest = 1) until arbitration.
REQ-028 No owner SHALL be preempted; an owner with s_waitrequest held high SHALL keep the bus indefinitely.
REQ-029 `proto_err` SHALL clear only on reset.

Reset
REQ-030 With reset high at an edge, the FSM SHALL enter IDLE, set last-served = m1 and clear proto_err.
REQ-031 After reset: grant = 00, s_read = s_write = 0, s_address = s_writedata = 0, s_byteenable = 0, m0/m1_waitrequest = 1, m0/m1_readdata = 0.
REQ-032 Reset mid-transfer SHALL abandon the transfer with no completion reported to either master.

Verification
REQ-033 Single read: m0_read = 1, address 0x04, slave waitrequest = 0, readdata 0x24030010 -> cycle 1 IDLE (m0_waitrequest = 1); cycle 2 grant = 01, m0_waitrequest = 0, m0_readdata = 0x24030010; cycle 3 grant = 00.
REQ-034 Tie: m0 and m1 both write from reset -> m0 granted first; on m0 completion, IDLE 1 cycle, then grant = 10; m1_waitrequest stays 1 throughout m0's ownership.
REQ-035 Slave stall: m1 write address 0x10, data 0x00000008, s_waitrequest = 1 for 3 cycles -> grant = 10 held 4 cycles; s_write = 1 and s_address = 0x10 throughout; completes on 4th.
REQ-036 Round-robin: m0 and m1 continuously requesting -> grants alternate 01, 10, 01, 10 with one IDLE cycle between each.
REQ-037 Protocol error: m0 read and write both high in OWN0 -> s_read = 0, s_write = 1, proto_err = 1 and remains 1 until reset; m0 dropping its request while s_waitrequest = 1 -> IDLE next cycle, proto_err = 1.
REQ-038 Reset mid-transfer: reset while OWN1 with s_waitrequest = 1 -> next cycle grant = 00, s_write = 0, proto_err = 0.
